// File: rtl/id_branch_comparator.sv
// ID-stage branch comparator: equality, signed/unsigned less-than and branch decision,
// with a stall-holding registered copy of the flags for the next pipeline stage.
module id_branch_comparator #(
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ID_rd1,
  input  logic [WIDTH-1:0] ID_rd2,
  input  logic [2:0]       br_op,
  input  logic             br_valid,
  input  logic             stall,
  output logic             zero,
  output logic             lt_s,
  output logic             lt_u,
  output logic             take,
  output logic [3:0]       flags_q,
  output logic             valid_q
);

  logic       zero_s;
  logic       lt_s_s;
  logic       lt_u_s;
  logic       cond_s;
  logic       take_s;
  logic [3:0] flags_r;
  logic       valid_r;

  // Operand compare: signed result reuses the unsigned compare unless the signs differ.
  always_comb begin
    zero_s = 1'b0;
    lt_u_s = 1'b0;
    lt_s_s = 1'b0;
    zero_s = (ID_rd1 == ID_rd2);
    lt_u_s = (ID_rd1 < ID_rd2);
    if (ID_rd1[WIDTH-1] != ID_rd2[WIDTH-1]) begin
      lt_s_s = ID_rd1[WIDTH-1];
    end else begin
      lt_s_s = lt_u_s;
    end
  end

  // Branch condition select and qualification with br_valid.
  always_comb begin
    cond_s = 1'b0;
    case (br_op)
      3'b000:  cond_s = zero_s;
      3'b001:  cond_s = ~zero_s;
      3'b010:  cond_s = lt_s_s;
      3'b011:  cond_s = ~lt_s_s;
      3'b100:  cond_s = lt_u_s;
      3'b101:  cond_s = ~lt_u_s;
      3'b110:  cond_s = 1'b1;
      3'b111:  cond_s = 1'b0;
      default: cond_s = 1'b0;
    endcase
    take_s = br_valid & cond_s;
  end

  // Pipeline register for flags and valid; stall holds, reset clears asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= 4'b0000;
      valid_r <= 1'b0;
    end else if (!stall) begin
      flags_r <= {take_s, lt_u_s, lt_s_s, zero_s};
      valid_r <= br_valid;
    end else begin
      flags_r <= flags_r;
      valid_r <= valid_r;
    end
  end

  assign zero    = zero_s;
  assign lt_s    = lt_s_s;
  assign lt_u    = lt_u_s;
  assign take    = take_s;
  assign flags_q = flags_r;
  assign valid_q = valid_r;

endmodule

// File: tb/tb_id_branch_comparator.sv
// Self-checking bench for id_branch_comparator: vector table, hand sequences for
// the registered path, and randomized checks against an arithmetic reference model.
module tb_id_branch_comparator;

  localparam int WIDTH = 19;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] ID_rd1;
  logic [WIDTH-1:0] ID_rd2;
  logic [2:0]       br_op;
  logic             br_valid;
  logic             stall;
  logic             zero;
  logic             lt_s;
  logic             lt_u;
  logic             take;
  logic [3:0]       flags_q;
  logic             valid_q;

  int checks;
  int errors;

  typedef struct {
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [2:0]       op;
    logic             v;
    logic [3:0]       exp;  // {take, lt_u, lt_s, zero}
  } vec_t;

  vec_t vecs[21];

  id_branch_comparator #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ID_rd1   (ID_rd1),
    .ID_rd2   (ID_rd2),
    .br_op    (br_op),
    .br_valid (br_valid),
    .stall    (stall),
    .zero     (zero),
    .lt_s     (lt_s),
    .lt_u     (lt_u),
    .take     (take),
    .flags_q  (flags_q),
    .valid_q  (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: interpret operands as integers and compare them directly.
  function automatic logic [3:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic [2:0] op, input logic v);
    longint ua, ub, sa, sb;
    logic eq, ltu, lts, cond;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= 64'sd262144) ? ua - 64'sd524288 : ua;
    sb = (ub >= 64'sd262144) ? ub - 64'sd524288 : ub;
    eq  = (ua == ub);
    ltu = (ua < ub);
    lts = (sa < sb);
    case (op)
      3'd0:    cond = eq;
      3'd1:    cond = !eq;
      3'd2:    cond = lts;
      3'd3:    cond = !lts;
      3'd4:    cond = ltu;
      3'd5:    cond = !ltu;
      3'd6:    cond = 1'b1;
      default: cond = 1'b0;
    endcase
    return {v & cond, ltu, lts, eq};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [2:0] op, input logic v);
    ID_rd1   = a;
    ID_rd2   = b;
    br_op    = op;
    br_valid = v;
  endtask

  initial begin
    logic [3:0] exp_flags;
    logic       exp_valid;
    logic [3:0] m;
    checks = 0;
    errors = 0;

    vecs[0] = '{19'h1A5A5, 19'h1A5A5, 3'd0, 1'b1, 4'b1001};
    vecs[1] = '{19'h15A5A, 19'h1A5A5, 3'd0, 1'b1, 4'b0110};
    vecs[2] = '{19'h7FFFF, 19'h7FFFF, 3'd0, 1'b1, 4'b1001};
    vecs[3] = '{19'h00000, 19'h7FFFF, 3'd0, 1'b1, 4'b0100};
    vecs[4] = '{19'h40000, 19'h3FFFF, 3'd0, 1'b1, 4'b0010};
    for (int k = 0; k < 8; k++) begin
      logic [7:0] take_seq;
      take_seq = 8'b0101_0110;  // bit k = expected take for br_op k
      vecs[5 + k]  = '{19'h15A5A, 19'h1A5A5, 3'(k), 1'b1, {take_seq[k], 3'b110}};
      vecs[13 + k] = '{19'h15A5A, 19'h1A5A5, 3'(k), 1'b0, 4'b0110};
    end

    // Reset with the clock not yet having produced an edge.
    rst_n = 1'b0;
    stall = 1'b0;
    drive(19'h00000, 19'h00000, 3'd0, 1'b1);
    #1;
    check("reset_flags_q", 32'(flags_q), 32'h0);
    check("reset_valid_q", 32'(valid_q), 32'h0);
    check("reset_zero", 32'(zero), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Combinational vector table.
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].rd1, vecs[i].rd2, vecs[i].op, vecs[i].v);
      #20;
      check($sformatf("vec%0d_flags", i), 32'({take, lt_u, lt_s, zero}), 32'(vecs[i].exp));
    end

    // Registered capture.
    @(negedge clk);
    stall = 1'b0;
    drive(19'h1A5A5, 19'h1A5A5, 3'd0, 1'b1);
    @(posedge clk); #1;
    check("capture_flags_q", 32'(flags_q), 32'h9);
    check("capture_valid_q", 32'(valid_q), 32'h1);

    // Stall hold over two edges, then release.
    @(negedge clk);
    stall = 1'b1;
    drive(19'h00000, 19'h7FFFF, 3'd0, 1'b1);
    @(posedge clk); #1;
    check("stall1_flags_q", 32'(flags_q), 32'h9);
    @(posedge clk); #1;
    check("stall2_flags_q", 32'(flags_q), 32'h9);
    @(negedge clk);
    stall = 1'b0;
    @(posedge clk); #1;
    check("release_flags_q", 32'(flags_q), 32'h4);
    check("release_valid_q", 32'(valid_q), 32'h1);

    // Asynchronous reset between edges, with stall also asserted.
    @(negedge clk);
    #2;
    stall = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async_rst_flags_q", 32'(flags_q), 32'h0);
    check("async_rst_valid_q", 32'(valid_q), 32'h0);
    check("async_rst_lt_u", 32'(lt_u), 32'h1);
    @(posedge clk); #1;
    check("rst_hold_flags_q", 32'(flags_q), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    @(posedge clk); #1;
    check("post_rst_flags_q", 32'(flags_q), 32'h4);
    check("post_rst_valid_q", 32'(valid_q), 32'h1);

    // Randomized operands, ops, valid and stall against the reference model.
    exp_flags = 4'b0100;
    exp_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [WIDTH-1:0] a, b;
      @(negedge clk);
      a = WIDTH'($urandom);
      case ($urandom_range(3, 0))
        0:       b = a;
        1:       b = a ^ (WIDTH'(1) << $urandom_range(WIDTH - 1, 0));
        2:       b = ($urandom_range(1, 0) == 0) ? 19'h40000 : 19'h3FFFF;
        default: b = WIDTH'($urandom);
      endcase
      drive(a, b, 3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)));
      stall = ($urandom_range(3, 0) == 0);
      #1;
      m = model(ID_rd1, ID_rd2, br_op, br_valid);
      check("rand_comb", 32'({take, lt_u, lt_s, zero}), 32'(m));
      if (!stall) begin
        exp_flags = m;
        exp_valid = br_valid;
      end else begin
        exp_flags = exp_flags;
      end
      @(posedge clk); #1;
      check("rand_flags_q", 32'(flags_q), 32'(exp_flags));
      check("rand_valid_q", 32'(valid_q), 32'(exp_valid));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
